rand_range_req: RTL
===================

RAND_RANGE_REQ -- requirements
Module: rand_range_req

Interface
REQ-001 SHALL have parameter MAX_TRY, default 8, meaning the number of next_out fetches allowed per request before fallback (range 1..255).
REQ-002 SHALL have port clk, input, 1 bit: system clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port req, input, 1 bit: start request; sampled only in IDLE.
REQ-005 SHALL have port limit, input, 16 bits: exclusive upper bound; sampled on the accepted req edge.
REQ-006 SHALL have port num_in, input, 16 bits: current value from the 16-bit LFSR generator.
REQ-007 SHALL have port next_out, output, 1 bit: advance strobe to the generator, which is rising-edge detected.
REQ-008 SHALL have port busy, output, 1 bit: high from the accepted req until done.
REQ-009 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port value, output, 16 bits: result, always < limit unless err is set.
REQ-011 SHALL have port fallback, output, 1 bit: qualifies done; value came from the fallback path.
REQ-012 SHALL have port err, output, 1 bit: qualifies done; limit was 0.

Function
REQ-013 SHALL implement the states IDLE, MASK, ISSUE, WAIT, EVAL and DONE.
REQ-014 IDLE with req=1 SHALL latch limit, clear the try counter, set busy and go to MASK; req while busy SHALL be ignored.
REQ-015 MASK SHALL compute mask = (limit-1) with every bit below its MSB set (OR-fold by shifts of 1, 2, 4 and 8), giving limit=1→0x0000, 4→0x0003, 5→0x0007, 0x8000→0x7FFF.
REQ-016 MASK with limit=0 SHALL go to DONE with err=1 and value=0, and SHALL issue no next_out.
REQ-017 ISSUE SHALL drive next_out=1 for exactly one cycle, increment the try counter and go to WAIT.
REQ-018 WAIT SHALL drive next_out=0 for one cycle so the generator updates, then go to EVAL.
REQ-019 next_out SHALL always have at least one low cycle between pulses.
REQ-020 EVAL SHALL form cand = num_in & mask.
REQ-021 In EVAL, if cand < limit, value SHALL be set to cand and the FSM SHALL go to DONE.
REQ-022 In EVAL, if cand >= limit and tries < MAX_TRY, the FSM SHALL go to ISSUE.
REQ-023 In EVAL, if cand >= limit and tries = MAX_TRY, value SHALL be set to cand - limit, fallback SHALL be set to 1 and the FSM SHALL go to DONE; cand - limit < limit holds by construction of the mask.
REQ-024 DONE SHALL assert done for one cycle with value, fallback and err valid, clear busy and return to IDLE.
REQ-025 value SHALL hold its result until the next done; fallback and err SHALL be cleared on the next accepted req.
REQ-026 A successful request SHALL take 4 + 3*(tries-1) + 1 cycles from the req edge to the done pulse.
REQ-027 All comparisons and the subtraction SHALL be unsigned 16-bit arithmetic with no wrap.

Reset
REQ-028 rst=0 SHALL immediately force IDLE, next_out=0, busy=0, done=0, value=0x0000, fallback=0, err=0 and tries=0.
REQ-029 rst asserted mid-request SHALL abort the request without a done pulse; the next req after release SHALL start cleanly.

Verification
REQ-030 Scenario: generator model reset to 0x0001, req with limit=4 -> one next_out pulse, num becomes 0x0002, done with value=2, fallback=0, err=0, 5 cycles req-to-done.
REQ-031 Scenario: req with limit=0 -> done with err=1, value=0, zero next_out pulses.
REQ-032 Scenario: num_in tied to 0x0007, MAX_TRY=8, limit=5 -> exactly 8 next_out pulses, each followed by a low cycle, then done with value=2 and fallback=1.
REQ-033 Scenario: limit=1 -> one next_out pulse, done with value=0 for any num_in.
REQ-034 Scenario: rst pulled low during WAIT of the second try -> next_out and busy drop the same cycle, no done; after release a req with limit=4 completes normally.
REQ-035 Scenario: req re-pulsed while busy -> ignored, exactly one done, limit changes after acceptance have no effect.

Source files
------------

// File: rtl/rand_range_req.sv
// rand_range_req: draws a uniform value below limit from an external LFSR by masked rejection sampling,
// falling back to cand - limit after MAX_TRY rejected draws.
module rand_range_req #(
    parameter int MAX_TRY = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [15:0] limit,
    input  logic [15:0] num_in,
    output logic        next_out,
    output logic        busy,
    output logic        done,
    output logic [15:0] value,
    output logic        fallback,
    output logic        err
);
    typedef enum logic [2:0] {IDLE, MASK, ISSUE, WAIT, EVAL, DONE} state_t;
    localparam logic [7:0] MAX_T = 8'(MAX_TRY);
    state_t state, state_nx;
    logic [15:0] lim, mask, lim_m1, m1, m2, m3, mask_nx, cand, diff;
    logic [7:0] tries;
    logic is_fit, is_last;
    always_comb begin
        lim_m1  = lim - 16'd1;
        m1      = lim_m1 | (lim_m1 >> 1);
        m2      = m1 | (m1 >> 2);
        m3      = m2 | (m2 >> 4);
        mask_nx = m3 | (m3 >> 8);
        cand    = num_in & mask;
        diff    = cand - lim;
        is_fit  = cand < lim;
        is_last = tries >= MAX_T;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = req ? MASK : IDLE;
            MASK:    state_nx = (lim == 16'd0) ? DONE : ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    state_nx = EVAL;
            EVAL:    state_nx = (is_fit || is_last) ? DONE : ISSUE;
            default: state_nx = IDLE;
        endcase
    end
    assign next_out = state == ISSUE;
    assign busy     = state != IDLE;
    assign done     = state == DONE;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            lim      <= '0;
            mask     <= '0;
            tries    <= '0;
            value    <= '0;
            fallback <= 1'b0;
            err      <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req) begin
                lim      <= limit;
                tries    <= '0;
                fallback <= 1'b0;
                err      <= 1'b0;
            end
            if (state == MASK) begin
                mask <= mask_nx;
                if (lim == 16'd0) begin
                    err   <= 1'b1;
                    value <= '0;
                end
            end
            if (state == ISSUE)
                tries <= tries + 8'd1;
            // the mask is below 2*limit, so cand - limit always lands in range
            if (state == EVAL && is_fit)
                value <= cand;
            else if (state == EVAL && is_last) begin
                value    <= diff;
                fallback <= 1'b1;
            end
        end
    end
endmodule
